// File: rtl/bcd_to_binary.sv
// Sequential five-digit BCD to binary converter (reverse double-dabble).
// Each SHIFT cycle produces one result bit. Results are published one cycle
// after the last iteration, together with a one-cycle done pulse.
module bcd_to_binary #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       bcd0,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd4,
  output logic [WIDTH-1:0] binary_out,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             invalid
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned JOIN_W = BCD_W + WIDTH;
  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BCD_W-1:0] bcd_reg_q, bcd_reg_d;
  logic [WIDTH-1:0] bin_reg_q, bin_reg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bad_q, bad_d;
  logic [WIDTH-1:0] binary_out_q, binary_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic             invalid_q, invalid_d;

  logic [BCD_W-1:0]  bcd_in_c;
  logic              in_invalid_c;
  logic [JOIN_W-1:0] shifted_c;
  logic [BCD_W-1:0]  bcd_adj_c;
  logic              accept_c;

  assign bcd_in_c = BCD_W'({bcd4, bcd3, bcd2, bcd1, bcd0});

  // Flag any input digit outside 0..9 so the conversion can be skipped.
  always_comb begin
    in_invalid_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in_c[4*i +: 4] > 4'd9) begin
        in_invalid_c = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift right, then pull back digits >= 8.
  always_comb begin
    shifted_c = {bcd_reg_q, bin_reg_q} >> 1;
    bcd_adj_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (shifted_c[WIDTH + 4*i +: 4] >= 4'd8) begin
        bcd_adj_c[4*i +: 4] = shifted_c[WIDTH + 4*i +: 4] - 4'd3;
      end else begin
        bcd_adj_c[4*i +: 4] = shifted_c[WIDTH + 4*i +: 4];
      end
    end
  end

  // A new request is taken whenever the converter is not iterating.
  assign accept_c = start && (state_q != SHIFT);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    bcd_reg_d    = bcd_reg_q;
    bin_reg_d    = bin_reg_q;
    count_d      = count_q;
    bad_d        = bad_q;
    binary_out_d = binary_out_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;
    invalid_d    = invalid_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        bcd_reg_d = bcd_adj_c;
        bin_reg_d = shifted_c[WIDTH-1:0];
        count_d   = count_q + CNT_W'(1);
        if (count_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Publish the result; a non-decimal input reports only invalid.
        done_d  = 1'b1;
        state_d = IDLE;
        if (bad_q) begin
          binary_out_d = '0;
          overflow_d   = 1'b0;
          invalid_d    = 1'b1;
        end else begin
          binary_out_d = bin_reg_q;
          overflow_d   = |bcd_reg_q;
          invalid_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture overrides the idle/return path; results above still publish.
    if (accept_c) begin
      bcd_reg_d = bcd_in_c;
      bin_reg_d = '0;
      count_d   = '0;
      bad_d     = in_invalid_c;
      state_d   = in_invalid_c ? DONE : SHIFT;
    end

    busy_d = (state_d == SHIFT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bcd_reg_q    <= '0;
      bin_reg_q    <= '0;
      count_q      <= '0;
      bad_q        <= 1'b0;
      binary_out_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcd_reg_q    <= bcd_reg_d;
      bin_reg_q    <= bin_reg_d;
      count_q      <= count_d;
      bad_q        <= bad_d;
      binary_out_q <= binary_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      invalid_q    <= invalid_d;
    end
  end

  assign binary_out = binary_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign invalid    = invalid_q;

endmodule
